// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the memory port arbiter.
// The optional address range check is enabled with ARB_ADDR_CHECK_EN.
package mem_arb_pkg;

  localparam int unsigned DEF_WORD_SIZE    = 32;
  localparam int unsigned DEF_IADDR_W      = 20;
  localparam int unsigned DEF_MEM_LAST     = 1048575;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // The starvation counter is 4 bits wide, so the limit is capped at 15.
  localparam int unsigned STARVE_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the memory port arbiter.
// slave: arbiter view; master: requester/memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned WORD_SIZE = mem_arb_pkg::DEF_WORD_SIZE,
  parameter int unsigned IADDR_W   = mem_arb_pkg::DEF_IADDR_W
);

  // Fetch requester
  logic                 if_req;
  logic [IADDR_W-1:0]   if_addr;
  logic                 if_gnt;
  logic [WORD_SIZE-1:0] if_rdata;
  logic                 if_rvalid;

  // Data requester
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_gnt;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_rvalid;
  logic                 d_err;

  // Unified memory
  logic [IADDR_W-1:0]   mem_i_address;
  logic                 mem_i_enable;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_data_in;
  logic                 mem_load;
  logic                 mem_store;
  logic [WORD_SIZE-1:0] mem_data_out;

  logic                 busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output if_gnt, if_rdata, if_rvalid,
    output d_gnt, d_rdata, d_rvalid, d_err,
    output mem_i_address, mem_i_enable, mem_address, mem_data_in,
    output mem_load, mem_store, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  if_gnt, if_rdata, if_rvalid,
    input  d_gnt, d_rdata, d_rvalid, d_err,
    input  mem_i_address, mem_i_enable, mem_address, mem_data_in,
    input  mem_load, mem_store, busy
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating starvation counter: counts data grants made while a fetch
// waits, and flags when the fetch must be granted next.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] r_count;

  // Clear has priority over increment; the count holds once it reaches LIM.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIM)) begin
      r_count <= r_count + STARVE_CNT_W'(1);
    end
  end

  assign o_at_limit = (r_count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-transaction arbiter in front of the unified memory. Serialises
// fetch and load/store requests, returns read data to the owner.
// Optional macro ARB_ADDR_CHECK_EN: data accesses above MEM_LAST are
// granted but suppressed at the memory and reported through d_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned IADDR_W      = DEF_IADDR_W,
  parameter int unsigned MEM_LAST     = DEF_MEM_LAST,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic               clock,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

`ifdef ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  localparam logic [WORD_SIZE-1:0] LAST_ADDR = WORD_SIZE'(MEM_LAST);

  arb_state_e           r_state;
  arb_state_e           w_next_state;
  arb_owner_e           r_owner;
  logic                 r_we;
  logic                 r_err;
  logic [IADDR_W-1:0]   r_iaddr;
  logic [WORD_SIZE-1:0] r_daddr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_if_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;

  logic w_grant_if;
  logic w_grant_d;
  logic w_at_limit;
  logic w_starve_inc;
  logic w_starve_clr;
  logic w_addr_oob;
  logic w_mem_i_enable;
  logic w_mem_load;
  logic w_mem_store;
  logic w_if_rvalid;
  logic w_d_rvalid;
  logic w_d_err;

  // Out-of-range flag; constant 0 when the check is compiled out.
  assign w_addr_oob = ADDR_CHECK && (bus.d_addr > LAST_ADDR);

  // Starvation bookkeeping: count data grants that bypass a waiting fetch.
  assign w_starve_inc = w_grant_d && bus.if_req;
  assign w_starve_clr = w_grant_if || ((r_state == IDLE) && !bus.if_req);

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_inc      (w_starve_inc),
    .i_clr      (w_starve_clr),
    .o_at_limit (w_at_limit)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant selection, next state and per-state memory strobes / responses.
  always_comb begin
    w_next_state   = r_state;
    w_grant_if     = 1'b0;
    w_grant_d      = 1'b0;
    w_mem_i_enable = 1'b0;
    w_mem_load     = 1'b0;
    w_mem_store    = 1'b0;
    w_if_rvalid    = 1'b0;
    w_d_rvalid     = 1'b0;
    w_d_err        = 1'b0;
    case (r_state)
      IDLE: begin
        // Grants are gated by reset so every output reads 0 while in reset.
        if (reset_n) begin
          if (bus.d_req && !(bus.if_req && w_at_limit)) begin
            w_grant_d = 1'b1;
          end else if (bus.if_req) begin
            w_grant_if = 1'b1;
          end
        end
        if (w_grant_d || w_grant_if) begin
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_owner == OWN_IF) begin
          w_mem_i_enable = 1'b1;
          w_mem_load     = 1'b1;
          w_next_state   = CAPTURE;
        end else if (r_we) begin
          w_mem_store  = !r_err;
          w_d_err      = r_err;
          w_next_state = IDLE;
        end else begin
          w_mem_load   = !r_err;
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        w_next_state = RESP;
      end
      RESP: begin
        if (r_owner == OWN_IF) begin
          w_if_rvalid = 1'b1;
        end else begin
          w_d_rvalid = 1'b1;
          w_d_err    = r_err;
        end
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request capture at grant and read-data capture in CAPTURE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_iaddr    <= '0;
      r_daddr    <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant_if) begin
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
        r_err   <= 1'b0;
        r_iaddr <= bus.if_addr;
      end
      if (w_grant_d) begin
        r_owner <= OWN_D;
        r_we    <= bus.d_we;
        r_err   <= w_addr_oob;
        r_daddr <= bus.d_addr;
        if (bus.d_we) begin
          r_wdata <= bus.d_wdata;
        end
      end
      if (r_state == CAPTURE) begin
        if (r_owner == OWN_IF) begin
          r_if_rdata <= bus.mem_data_out;
        end else begin
          r_d_rdata <= r_err ? '0 : bus.mem_data_out;
        end
      end
    end
  end

  assign bus.if_gnt        = w_grant_if;
  assign bus.if_rdata      = r_if_rdata;
  assign bus.if_rvalid     = w_if_rvalid;
  assign bus.d_gnt         = w_grant_d;
  assign bus.d_rdata       = r_d_rdata;
  assign bus.d_rvalid      = w_d_rvalid;
  assign bus.d_err         = w_d_err;
  assign bus.mem_i_address = r_iaddr;
  assign bus.mem_i_enable  = w_mem_i_enable;
  assign bus.mem_address   = r_daddr;
  assign bus.mem_data_in   = r_wdata;
  assign bus.mem_load      = w_mem_load;
  assign bus.mem_store     = w_mem_store;
  assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a scoreboard of expected
// read responses and a one-cycle-latency memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned WS       = 32;
  localparam int unsigned IW       = 20;
  localparam int unsigned LIMIT    = 4;
  localparam int unsigned MEM_LAST = 1048575;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.WORD_SIZE(WS), .IADDR_W(IW)) bus ();

  mem_port_arbiter #(
    .WORD_SIZE    (WS),
    .IADDR_W      (IW),
    .MEM_LAST     (MEM_LAST),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] rd_i(input logic [19:0] a);
    return {12'hC3A, a} ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] rd_d(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: read data appears the cycle after the load strobe.
  logic [31:0] r_mem_q   = '0;
  logic        force_en  = 1'b0;
  logic [31:0] force_val = '0;
  always @(posedge clock) begin
    if (bus.mem_load)
      r_mem_q <= bus.mem_i_enable ? rd_i(bus.mem_i_address) : rd_d(bus.mem_address);
  end
  assign bus.mem_data_out = force_en ? force_val : r_mem_q;

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.d_err, bus.mem_i_enable,
         bus.mem_load, bus.mem_store, bus.busy} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {bus.if_gnt, bus.if_rvalid, bus.d_gnt,
        bus.d_rvalid, bus.d_err, bus.mem_i_enable, bus.mem_load, bus.mem_store, bus.busy});
    end
    checks++;
    if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", {bus.if_rdata, bus.d_rdata});
    end
    checks++;
    if ({bus.mem_i_address, bus.mem_address, bus.mem_data_in} !== 84'h0) begin
      errors++; $display("FAIL reset_mem_bus got %h want 0", {bus.mem_i_address, bus.mem_address, bus.mem_data_in});
    end
    bus.if_req = 1'b1; bus.d_req = 1'b1; #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b want 00", {bus.if_gnt, bus.d_gnt});
    end
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    exp_t e;
    @(negedge clock);
    bus.if_req = 1'b1; bus.if_addr = 20'd7; #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt got %b want 10", {bus.if_gnt, bus.d_gnt});
    end
    sb.push_back('{1'b0, 32'h2540_0014});
    @(negedge clock);
    bus.if_req = 1'b0;
    checks++;
    if ({bus.mem_i_enable, bus.mem_load, bus.mem_store, bus.busy} !== 4'b1101) begin
      errors++; $display("FAIL fetch_issue got %b want 1101", {bus.mem_i_enable, bus.mem_load, bus.mem_store, bus.busy});
    end
    checks++;
    if (bus.mem_i_address !== 20'd7) begin
      errors++; $display("FAIL fetch_iaddr got %h want 7", bus.mem_i_address);
    end
    @(negedge clock);
    force_en = 1'b1; force_val = 32'h2540_0014;
    checks++;
    if ({bus.mem_i_enable, bus.mem_load, bus.if_rvalid} !== 3'b000) begin
      errors++; $display("FAIL fetch_capture got %b want 000", {bus.mem_i_enable, bus.mem_load, bus.if_rvalid});
    end
    @(negedge clock);
    force_en = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.d_rvalid} !== 2'b10) begin
      errors++; $display("FAIL fetch_rvalid got %b want 10", {bus.if_rvalid, bus.d_rvalid});
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.if_rdata !== e.data) begin
        errors++; $display("FAIL fetch_rdata got %h want %h", bus.if_rdata, e.data);
      end
    end
    @(negedge clock);
    checks++;
    if ({bus.if_rvalid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL fetch_done got %b want 00", {bus.if_rvalid, bus.busy});
    end
  endtask

  task automatic test_store();
    @(negedge clock);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd229376; bus.d_wdata = 32'hA5; #1;
    checks++;
    if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin
      errors++; $display("FAIL store_gnt got %b want 10", {bus.d_gnt, bus.if_gnt});
    end
    @(negedge clock);
    idle_inputs();
    checks++;
    if ({bus.mem_store, bus.mem_load, bus.mem_i_enable, bus.d_err} !== 4'b1000) begin
      errors++; $display("FAIL store_issue got %b want 1000", {bus.mem_store, bus.mem_load, bus.mem_i_enable, bus.d_err});
    end
    checks++;
    if ({bus.mem_address, bus.mem_data_in} !== {32'd229376, 32'hA5}) begin
      errors++; $display("FAIL store_bus got %h want %h", {bus.mem_address, bus.mem_data_in}, {32'd229376, 32'hA5});
    end
    @(negedge clock);
    checks++;
    if ({bus.busy, bus.mem_store, bus.d_rvalid} !== 3'b000) begin
      errors++; $display("FAIL store_done got %b want 000", {bus.busy, bus.mem_store, bus.d_rvalid});
    end
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (bus.d_rvalid !== 1'b0) begin
        errors++; $display("FAIL store_no_rvalid got %b want 0", bus.d_rvalid);
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    @(negedge clock);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd229376; #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL load_gnt got %b want 1", bus.d_gnt);
    end
    sb.push_back('{1'b1, rd_d(32'd229376)});
    @(negedge clock);
    idle_inputs();
    checks++;
    if ({bus.mem_load, bus.mem_i_enable, bus.mem_store} !== 3'b100) begin
      errors++; $display("FAIL load_issue got %b want 100", {bus.mem_load, bus.mem_i_enable, bus.mem_store});
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.d_rvalid, bus.if_rvalid, bus.d_err} !== 3'b100) begin
      errors++; $display("FAIL load_rvalid got %b want 100", {bus.d_rvalid, bus.if_rvalid, bus.d_err});
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.d_rdata !== e.data) begin
        errors++; $display("FAIL load_rdata got %h want %h", bus.d_rdata, e.data);
      end
    end
    checks++;
    if (bus.if_rdata !== 32'h2540_0014) begin
      errors++; $display("FAIL if_rdata_hold got %h want 25400014", bus.if_rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_starvation();
    exp_t e;
    logic exp_d[10];
    logic got_d[16];
    int   ngr = 0;
    int   cnt = 0;
    bit   dropped = 1'b0;
    bit   done = 1'b0;
    bit   granted;
    for (int k = 0; k < 10; k++) begin
      if (cnt == int'(LIMIT)) begin exp_d[k] = 1'b0; cnt = 0; end
      else begin exp_d[k] = 1'b1; cnt++; end
    end
    @(negedge clock);
    bus.if_req = 1'b1; bus.if_addr = 20'h00123;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_4000;
    #1;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (bus.if_rvalid || bus.d_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL starve_unexpected_rvalid got %b want none", {bus.if_rvalid, bus.d_rvalid});
        end else begin
          e = sb.pop_front();
          checks++;
          if ({bus.d_rvalid, bus.if_rvalid, (e.is_d ? bus.d_rdata : bus.if_rdata)} !== {e.is_d, !e.is_d, e.data}) begin
            errors++; $display("FAIL starve_resp got %b%b %h want %b%b %h", bus.d_rvalid, bus.if_rvalid,
              (e.is_d ? bus.d_rdata : bus.if_rdata), e.is_d, !e.is_d, e.data);
          end
        end
      end
      granted = bus.if_gnt || bus.d_gnt;
      if (granted) begin
        if (ngr < 16) got_d[ngr] = bus.d_gnt;
        sb.push_back('{bus.d_gnt, bus.d_gnt ? rd_d(32'h0000_4000) : rd_i(20'h00123)});
        ngr++;
      end else if (ngr >= 10 && !dropped) begin
        idle_inputs();
        dropped = 1'b1;
      end
      if (dropped && sb.size() == 0) done = 1'b1;
      @(negedge clock);
    end
    idle_inputs();
    checks++;
    if (!done || ngr != 10) begin
      errors++; $display("FAIL starve_complete got grants=%0d done=%0b want grants=10 done=1", ngr, done);
    end
    for (int k = 0; k < 10; k++) begin
      if (k < ngr) begin
        checks++;
        if (got_d[k] !== exp_d[k]) begin
          errors++; $display("FAIL starve_order[%0d] got d=%b want d=%b", k, got_d[k], exp_d[k]);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat = 0;
    bit   seen = 1'b0;
    @(negedge clock);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100; #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt got %b want 1", bus.d_gnt);
    end
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy got %b want 1", bus.busy);
    end
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.d_rvalid, bus.busy, bus.d_gnt, bus.mem_load, bus.d_err} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctrl got %b want 0", {bus.d_rvalid, bus.busy, bus.d_gnt, bus.mem_load, bus.d_err});
    end
    checks++;
    if ({bus.d_rdata, bus.if_rdata, bus.mem_address} !== 96'h0) begin
      errors++; $display("FAIL rstmid_data got %h want 0", {bus.d_rdata, bus.if_rdata, bus.mem_address});
    end
    reset_n = 1'b1;
    @(negedge clock);
    bus.if_req = 1'b1; bus.if_addr = 20'h00055; #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_fetch_gnt got %b want 1", bus.if_gnt);
    end
    sb.push_back('{1'b0, rd_i(20'h00055)});
    for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
      @(negedge clock);
      idle_inputs();
      lat++;
      if (bus.if_rvalid) begin
        seen = 1'b1;
        e = sb.pop_front();
        checks++;
        if ({lat, bus.if_rdata} !== {32'd3, e.data}) begin
          errors++; $display("FAIL rstmid_fetch_resp got lat=%0d %h want lat=3 %h", lat, bus.if_rdata, e.data);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstmid_fetch_timeout got none want if_rvalid");
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic test_addr_check();
    // Out-of-range load
    @(negedge clock);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd1048576; #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL oob_load_gnt got %b want 1", bus.d_gnt);
    end
    @(negedge clock);
    idle_inputs();
    checks++;
`ifdef ARB_ADDR_CHECK_EN
    if ({bus.mem_load, bus.mem_store, bus.d_err} !== 3'b000) begin
      errors++; $display("FAIL oob_load_issue got %b want 000", {bus.mem_load, bus.mem_store, bus.d_err});
    end
`else
    if ({bus.mem_load, bus.mem_store, bus.d_err} !== 3'b100) begin
      errors++; $display("FAIL oob_load_issue got %b want 100", {bus.mem_load, bus.mem_store, bus.d_err});
    end
`endif
    repeat (2) @(negedge clock);
    checks++;
`ifdef ARB_ADDR_CHECK_EN
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL oob_load_resp got %b%b %h want 11 0", bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
`else
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, rd_d(32'd1048576)}) begin
      errors++; $display("FAIL oob_load_resp got %b%b %h want 10 %h", bus.d_rvalid, bus.d_err, bus.d_rdata, rd_d(32'd1048576));
    end
`endif
    // Out-of-range store
    @(negedge clock);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'hFFFF_FFF0; bus.d_wdata = 32'h1234_5678;
    @(negedge clock);
    idle_inputs();
    checks++;
`ifdef ARB_ADDR_CHECK_EN
    if ({bus.mem_store, bus.d_err} !== 2'b01) begin
      errors++; $display("FAIL oob_store_issue got %b want 01", {bus.mem_store, bus.d_err});
    end
`else
    if ({bus.mem_store, bus.d_err} !== 2'b10) begin
      errors++; $display("FAIL oob_store_issue got %b want 10", {bus.mem_store, bus.d_err});
    end
`endif
    @(negedge clock);
    checks++;
    if ({bus.d_err, bus.busy, bus.d_rvalid} !== 3'b000) begin
      errors++; $display("FAIL oob_store_done got %b want 000", {bus.d_err, bus.busy, bus.d_rvalid});
    end
    // Highest legal address is an ordinary load
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = MEM_LAST;
    @(negedge clock);
    idle_inputs();
    checks++;
    if ({bus.mem_load, bus.mem_address} !== {1'b1, 32'(MEM_LAST)}) begin
      errors++; $display("FAIL last_load_issue got %b %h want 1 %h", bus.mem_load, bus.mem_address, 32'(MEM_LAST));
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, rd_d(32'(MEM_LAST))}) begin
      errors++; $display("FAIL last_load_resp got %b%b %h want 10 %h", bus.d_rvalid, bus.d_err, bus.d_rdata, rd_d(32'(MEM_LAST)));
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          n = 0;
    int          wait_cyc = 0;
    bit          pending = 1'b0;
    bit          done = 1'b0;
    int unsigned kind = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clock);
      if (bus.if_rvalid || bus.d_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_rvalid got %b want none", {bus.if_rvalid, bus.d_rvalid});
        end else begin
          e = sb.pop_front();
          checks++;
          if ({bus.d_rvalid, bus.if_rvalid, (e.is_d ? bus.d_rdata : bus.if_rdata)} !== {e.is_d, !e.is_d, e.data}) begin
            errors++; $display("FAIL b2b_resp got %b%b %h want %b%b %h", bus.d_rvalid, bus.if_rvalid,
              (e.is_d ? bus.d_rdata : bus.if_rdata), e.is_d, !e.is_d, e.data);
          end
        end
      end
      if (!pending) begin
        idle_inputs();
        if (n < 12) begin
          kind = $urandom_range(0, 2);
          if (kind == 0) begin
            bus.if_req = 1'b1; bus.if_addr = 20'($urandom_range(0, 20'hFFFFF));
          end else begin
            bus.d_req = 1'b1; bus.d_we = (kind == 2); bus.d_addr = $urandom_range(0, MEM_LAST);
            bus.d_wdata = $urandom;
          end
          pending = 1'b1;
          wait_cyc = 0;
        end
      end
      #1;
      if (pending) begin
        if (bus.if_gnt || bus.d_gnt) begin
          checks++;
          if ({bus.if_gnt, bus.d_gnt} !== {kind == 0, kind != 0}) begin
            errors++; $display("FAIL b2b_gnt got %b want %b", {bus.if_gnt, bus.d_gnt}, {kind == 0, kind != 0});
          end
          if (kind == 0) sb.push_back('{1'b0, rd_i(bus.if_addr)});
          else if (kind == 1) sb.push_back('{1'b1, rd_d(bus.d_addr)});
          pending = 1'b0;
          n++;
        end else begin
          wait_cyc++;
          if (wait_cyc > 8) begin
            checks++; errors++;
            $display("FAIL b2b_gnt_timeout got none want grant");
            pending = 1'b0;
            n++;
          end
        end
      end
      if (n == 12 && !pending && sb.size() == 0 && !bus.busy) done = 1'b1;
    end
    idle_inputs();
    checks++;
    if (!done) begin
      errors++; $display("FAIL b2b_complete got n=%0d outstanding=%0d want n=12 outstanding=0", n, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_starvation();
    test_reset_mid();
    test_addr_check();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
